// File: rtl/switch_allocator.sv
// Round-robin switch allocator for an input-queued NoC router: grants each output
// to one requesting input per cycle, gated by per-output downstream credits.
module switch_allocator #(
    parameter int P     = 7,
    parameter int B     = 4,
    parameter int UTURN = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [P*P-1:0] dest_port_req,
    output logic [P*P-1:0] grant_dest_port,
    output logic [P*P-1:0] xbar_sel,
    output logic [P-1:0]   flit_out_wr,
    input  logic [P-1:0]   credit_in,
    output logic           credit_err
);

    localparam int          PW   = (P > 1) ? $clog2(P) : 1;
    localparam logic [B:0]  DCAP = {1'b1, {B{1'b0}}};

    logic [PW-1:0]  ptr_q [P];
    logic [PW-1:0]  ptr_d [P];
    logic [B:0]     cnt_q [P];
    logic [B:0]     cnt_d [P];
    logic [P*P-1:0] grant_q, grant_d;
    logic [P*P-1:0] xsel_q, xsel_d;
    logic [P-1:0]   wr_q, alloc;
    logic           err_q, err_d;

    logic           found;
    logic [PW-1:0]  win;
    int             idx;

    always_comb begin
        grant_d = '0;
        xsel_d  = '0;
        alloc   = '0;
        err_d   = err_q;
        found   = 1'b0;
        win     = '0;
        idx     = 0;
        for (int o = 0; o < P; o++) begin
            ptr_d[o] = ptr_q[o];
            cnt_d[o] = cnt_q[o];
            found    = 1'b0;
            win      = '0;
            // Scan inputs starting at the pointer, wrapping modulo P; first eligible wins.
            for (int k = 0; k < P; k++) begin
                idx = int'(ptr_q[o]) + k;
                if (idx >= P) idx = idx - P;
                if (!found && dest_port_req[idx*P + o] && (UTURN != 0 || idx != o)
                    && cnt_q[o] != '0) begin
                    found = 1'b1;
                    win   = PW'(idx);
                end
            end
            if (found) begin
                alloc[o]                    = 1'b1;
                grant_d[int'(win)*P + o]    = 1'b1;
                xsel_d[o*P + int'(win)]     = 1'b1;
                ptr_d[o] = (win == PW'(P-1)) ? '0 : win + PW'(1);
            end
            // A credit and an allocation on the same edge cancel; excess credit is flagged.
            case ({alloc[o], credit_in[o]})
                2'b10: cnt_d[o] = cnt_q[o] - 1'b1;
                2'b01: begin
                    if (cnt_q[o] == DCAP) err_d = 1'b1;
                    else                  cnt_d[o] = cnt_q[o] + 1'b1;
                end
                default: cnt_d[o] = cnt_q[o];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q <= '0;
            xsel_q  <= '0;
            wr_q    <= '0;
            err_q   <= 1'b0;
            for (int o = 0; o < P; o++) begin
                ptr_q[o] <= '0;
                cnt_q[o] <= DCAP;
            end
        end else begin
            grant_q <= grant_d;
            xsel_q  <= xsel_d;
            wr_q    <= alloc;
            err_q   <= err_d;
            for (int o = 0; o < P; o++) begin
                ptr_q[o] <= ptr_d[o];
                cnt_q[o] <= cnt_d[o];
            end
        end
    end

    assign grant_dest_port = grant_q;
    assign xbar_sel        = xsel_q;
    assign flit_out_wr     = wr_q;
    assign credit_err      = err_q;

endmodule

// File: tb/tb_switch_allocator.sv
// Directed testbench for switch_allocator (P=7, B=4, UTURN=0).
module tb_switch_allocator;

    localparam int P = 7;
    localparam int B = 4;

    logic           clk;
    logic           rst_n;
    logic [P*P-1:0] dest_port_req;
    logic [P*P-1:0] grant_dest_port;
    logic [P*P-1:0] xbar_sel;
    logic [P-1:0]   flit_out_wr;
    logic [P-1:0]   credit_in;
    logic           credit_err;

    int n_checks = 0;
    int n_fail   = 0;

    switch_allocator #(.P(P), .B(B), .UTURN(0)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .dest_port_req   (dest_port_req),
        .grant_dest_port (grant_dest_port),
        .xbar_sel        (xbar_sel),
        .flit_out_wr     (flit_out_wr),
        .credit_in       (credit_in),
        .credit_err      (credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and land 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        dest_port_req = '0;
        credit_in     = '0;
        rst_n         = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (grant_dest_port !== '0 || xbar_sel !== '0 || flit_out_wr !== '0 || credit_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: grant=%h xsel=%h wr=%b err=%b, required all 0",
                     grant_dest_port, xbar_sel, flit_out_wr, credit_err);
        end
        for (int o = 0; o < P; o++) begin
            n_checks++;
            if (dut.cnt_q[o] !== 5'd16 || dut.ptr_q[o] !== 3'd0) begin
                n_fail++;
                $display("FAIL reset_state o=%0d: cnt=%0d ptr=%0d, required cnt=16 ptr=0",
                         o, dut.cnt_q[o], dut.ptr_q[o]);
            end
        end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [P*P-1:0] exp_x;
        do_reset();
        exp_x = '0;
        exp_x[3*P+0] = 1'b1;
        dest_port_req = '0;
        dest_port_req[0*P+3] = 1'b1;
        step();
        dest_port_req = '0;
        n_checks++;
        if (grant_dest_port !== 49'h8 || xbar_sel !== exp_x || flit_out_wr !== 7'b0001000) begin
            n_fail++;
            $display("FAIL single_grant: grant=%h xsel=%h wr=%b, required grant=8 xsel=%h wr=0001000",
                     grant_dest_port, xbar_sel, flit_out_wr, exp_x);
        end
        n_checks++;
        if (dut.cnt_q[3] !== 5'd15 || dut.ptr_q[3] !== 3'd1) begin
            n_fail++;
            $display("FAIL single_state: cnt=%0d ptr=%0d, required cnt=15 ptr=1",
                     dut.cnt_q[3], dut.ptr_q[3]);
        end
        step();
        n_checks++;
        if (grant_dest_port !== '0 || flit_out_wr !== '0) begin
            n_fail++;
            $display("FAIL single_idle: grant=%h wr=%b, required 0", grant_dest_port, flit_out_wr);
        end
    endtask

    task automatic test_round_robin();
        int exp_w [6] = '{1, 2, 4, 1, 2, 4};
        logic [P*P-1:0] eg;
        do_reset();
        dest_port_req = '0;
        dest_port_req[1*P+5] = 1'b1;
        dest_port_req[2*P+5] = 1'b1;
        dest_port_req[4*P+5] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            eg = '0;
            eg[exp_w[c]*P+5] = 1'b1;
            n_checks++;
            if (grant_dest_port !== eg || xbar_sel[5*P +: P] !== 7'(1 << exp_w[c])
                || flit_out_wr !== 7'b0100000) begin
                n_fail++;
                $display("FAIL rr_cycle%0d: grant=%h sel5=%b wr=%b, required winner in%0d",
                         c, grant_dest_port, xbar_sel[5*P +: P], flit_out_wr, exp_w[c]);
            end
        end
        dest_port_req = '0;
    endtask

    task automatic test_multicast();
        logic [P*P-1:0] exp_x;
        do_reset();
        exp_x = '0;
        exp_x[1*P+0] = 1'b1;
        exp_x[2*P+0] = 1'b1;
        exp_x[6*P+0] = 1'b1;
        dest_port_req = 49'h46;
        step();
        dest_port_req = '0;
        n_checks++;
        if (grant_dest_port !== 49'h46 || xbar_sel !== exp_x || flit_out_wr !== 7'b1000110) begin
            n_fail++;
            $display("FAIL multicast: grant=%h xsel=%h wr=%b, required grant=46 xsel=%h wr=1000110",
                     grant_dest_port, xbar_sel, flit_out_wr, exp_x);
        end
    endtask

    task automatic test_credit_exhaust();
        int grants;
        do_reset();
        grants = 0;
        dest_port_req = '0;
        dest_port_req[2*P+4] = 1'b1;
        for (int c = 0; c < 17; c++) begin
            step();
            if (grant_dest_port[2*P+4] === 1'b1) grants++;
        end
        n_checks++;
        if (grants !== 16 || dut.cnt_q[4] !== 5'd0) begin
            n_fail++;
            $display("FAIL credit_exhaust: grants=%0d cnt=%0d, required 16 and 0", grants, dut.cnt_q[4]);
        end
        credit_in[4] = 1'b1;
        step();
        credit_in = '0;
        n_checks++;
        if (grant_dest_port !== '0 || dut.cnt_q[4] !== 5'd1) begin
            n_fail++;
            $display("FAIL credit_return_lat1: grant=%h cnt=%0d, required grant=0 cnt=1",
                     grant_dest_port, dut.cnt_q[4]);
        end
        step();
        n_checks++;
        if (grant_dest_port[2*P+4] !== 1'b1 || flit_out_wr !== 7'b0010000) begin
            n_fail++;
            $display("FAIL credit_return_grant: grant=%h wr=%b, required in2->out4",
                     grant_dest_port, flit_out_wr);
        end
        step();
        n_checks++;
        if (grant_dest_port !== '0) begin
            n_fail++;
            $display("FAIL credit_reblock: grant=%h, required 0", grant_dest_port);
        end
        dest_port_req = '0;
    endtask

    task automatic test_credit_boundary();
        do_reset();
        dest_port_req = '0;
        dest_port_req[0*P+1] = 1'b1;
        step();
        dest_port_req = '0;
        step();
        dest_port_req[0*P+1] = 1'b1;
        credit_in[1] = 1'b1;
        step();
        dest_port_req = '0;
        credit_in = '0;
        n_checks++;
        if (grant_dest_port !== 49'h2 || dut.cnt_q[1] !== 5'd15 || credit_err !== 1'b0) begin
            n_fail++;
            $display("FAIL alloc_and_credit: grant=%h cnt=%0d err=%b, required grant=2 cnt=15 err=0",
                     grant_dest_port, dut.cnt_q[1], credit_err);
        end
        credit_in[1] = 1'b1;
        step();
        n_checks++;
        if (dut.cnt_q[1] !== 5'd16 || credit_err !== 1'b0) begin
            n_fail++;
            $display("FAIL credit_to_full: cnt=%0d err=%b, required cnt=16 err=0", dut.cnt_q[1], credit_err);
        end
        step();
        credit_in = '0;
        n_checks++;
        if (dut.cnt_q[1] !== 5'd16 || credit_err !== 1'b1) begin
            n_fail++;
            $display("FAIL credit_overflow: cnt=%0d err=%b, required cnt=16 err=1", dut.cnt_q[1], credit_err);
        end
        step();
        step();
        n_checks++;
        if (credit_err !== 1'b1) begin
            n_fail++;
            $display("FAIL credit_err_sticky: err=%b, required 1", credit_err);
        end
    endtask

    task automatic test_uturn_and_async_reset();
        logic [P*P-1:0] eg;
        do_reset();
        eg = '0;
        eg[3*P+2] = 1'b1;
        dest_port_req = '0;
        dest_port_req[3*P+3] = 1'b1;
        dest_port_req[3*P+2] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if (grant_dest_port !== eg || flit_out_wr !== 7'b0000100) begin
                n_fail++;
                $display("FAIL uturn_mask_c%0d: grant=%h wr=%b, required grant=%h wr=0000100",
                         c, grant_dest_port, flit_out_wr, eg);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (grant_dest_port !== '0 || xbar_sel !== '0 || flit_out_wr !== '0
            || dut.cnt_q[2] !== 5'd16 || dut.ptr_q[2] !== 3'd0) begin
            n_fail++;
            $display("FAIL async_reset: grant=%h xsel=%h wr=%b cnt2=%0d ptr2=%0d, required 0 and cnt=16",
                     grant_dest_port, xbar_sel, flit_out_wr, dut.cnt_q[2], dut.ptr_q[2]);
        end
        dest_port_req = '0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n         = 1'b0;
        dest_port_req = '0;
        credit_in     = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_multicast();
        test_credit_exhaust();
        test_credit_boundary();
        test_uturn_and_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
